// File: rtl/spi_slot_dispatch_pkg.sv
// Shared definitions for the SPI slot dispatcher:
// command field positions, FSM encoding, timeout fill.
package spi_slot_dispatch_pkg;

    localparam int CMD_WR_BIT  = 15;
    localparam int CMD_SLOT_HI = 10;
    localparam int CMD_SLOT_LO = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // A timed-out read returns every bit set to this value.
    localparam logic TIMEOUT_FILL_BIT = 1'b1;

endpackage

// File: rtl/spi_dispatch_timer.sv
// Loadable down-counter with expire flag, used to bound
// how long the dispatcher waits for a slot acknowledge.
module spi_dispatch_timer (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: load wins, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == 8'd0);

endmodule

// File: rtl/spi_slot_dispatch.sv
// SPI frame to slot req/ack dispatcher, single outstanding.
// Optional timeout under SPI_DISPATCH_TIMEOUT_EN.
module spi_slot_dispatch
    import spi_slot_dispatch_pkg::*;
#(
    parameter int NUM_SLOTS      = 7,
    parameter int DATA_WIDTH     = 40,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [15:0]                     cmd_in,
    input  logic [7:0]                      addr_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            addr_valid,
    input  logic                            data_valid,
    output logic [NUM_SLOTS-1:0]            slot_req,
    output logic                            slot_we,
    output logic [7:0]                      slot_addr,
    output logic [DATA_WIDTH-1:0]           slot_wdata,
    input  logic [NUM_SLOTS-1:0]            slot_ack,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] slot_rdata,
    output logic [DATA_WIDTH-1:0]           rd_data_out,
    output logic                            rd_data_valid,
    output logic                            busy,
    output logic                            err_badslot,
    output logic                            err_overrun,
    output logic                            err_timeout
);

    state_e                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic                  we_q, we_d;
    logic [7:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  bad_q, bad_d;
    logic                  ovr_q, ovr_d;
    logic                  to_q, to_d;

    logic                  trig_we;
    logic [2:0]            trig_idx;
    logic                  trig;
    logic                  trig_bad;
    logic [NUM_SLOTS-1:0]  req_vec;
    logic                  ack_hit;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  tmr_load;
    logic                  tmr_expired;
    logic [15:0]           unused_cmd;

    assign trig_we  = cmd_in[CMD_WR_BIT];
    assign trig_idx = cmd_in[CMD_SLOT_HI:CMD_SLOT_LO];
    assign trig     = (addr_valid && !trig_we)
                   || (data_valid && trig_we);
    assign trig_bad = {1'b0, trig_idx} >= 4'(NUM_SLOTS);
    assign unused_cmd = cmd_in;

    // One-hot request and read-data select for the latched slot.
    always_comb begin
        req_vec   = '0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (idx_q == 3'(k)) begin
                req_vec[k] = (state_q == ST_REQ);
                sel_rdata  = slot_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ack_hit = |(slot_ack & req_vec);

`ifdef SPI_DISPATCH_TIMEOUT_EN
    spi_dispatch_timer u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (8'(TIMEOUT_CYCLES - 1)),
        .en       (state_q == ST_REQ),
        .expired  (tmr_expired)
    );
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    logic unused_tmr;
    assign tmr_expired = 1'b0;
    assign unused_tmr  = tmr_load ^ to_q;
`endif

    // Next-state, latching and one-cycle pulse generation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        bad_d    = 1'b0;
        ovr_d    = trig && (state_q != ST_IDLE);
        to_d     = 1'b0;
        tmr_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    idx_d  = trig_idx;
                    we_d   = trig_we;
                    addr_d = addr_in;
                    if (trig_we) begin
                        wdata_d = data_in;
                    end
                    if (trig_bad) begin
                        state_d = ST_RESP;
                        bad_d   = 1'b1;
                        if (!trig_we) begin
                            rdata_d  = '0;
                            rvalid_d = 1'b1;
                        end
                    end else begin
                        state_d  = ST_REQ;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (ack_hit) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        rdata_d  = sel_rdata;
                        rvalid_d = 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_RESP;
                    to_d    = 1'b1;
                    if (!we_q) begin
                        rdata_d  = {DATA_WIDTH{TIMEOUT_FILL_BIT}};
                        rvalid_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            we_q     <= 1'b0;
            addr_q   <= 8'd0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            bad_q    <= 1'b0;
            ovr_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            bad_q    <= bad_d;
            ovr_q    <= ovr_d;
            to_q     <= to_d;
        end
    end

    assign slot_req      = req_vec;
    assign slot_we       = we_q && (state_q == ST_REQ);
    assign slot_addr     = addr_q;
    assign slot_wdata    = wdata_q;
    assign rd_data_out   = rdata_q;
    assign rd_data_valid = rvalid_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_badslot   = bad_q;
    assign err_overrun   = ovr_q;
`ifdef SPI_DISPATCH_TIMEOUT_EN
    assign err_timeout   = to_q;
`else
    assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slot_dispatch.sv
// Directed bench for spi_slot_dispatch.
// Define SPI_DISPATCH_TIMEOUT_EN to cover the timeout path.
module tb_spi_slot_dispatch;

    localparam int NS = 7;
    localparam int DW = 40;

    logic           clk = 1'b0;
    logic           resetn;
    logic [15:0]    cmd_in;
    logic [7:0]     addr_in;
    logic [DW-1:0]  data_in;
    logic           addr_valid;
    logic           data_valid;
    logic [NS-1:0]  slot_req;
    logic           slot_we;
    logic [7:0]     slot_addr;
    logic [DW-1:0]  slot_wdata;
    logic [NS-1:0]  slot_ack;
    logic [NS*DW-1:0] slot_rdata;
    logic [DW-1:0]  rd_data_out;
    logic           rd_data_valid;
    logic           busy;
    logic           err_badslot;
    logic           err_overrun;
    logic           err_timeout;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_slot_dispatch #(
        .NUM_SLOTS      (NS),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_in        (cmd_in),
        .addr_in       (addr_in),
        .data_in       (data_in),
        .addr_valid    (addr_valid),
        .data_valid    (data_valid),
        .slot_req      (slot_req),
        .slot_we       (slot_we),
        .slot_addr     (slot_addr),
        .slot_wdata    (slot_wdata),
        .slot_ack      (slot_ack),
        .slot_rdata    (slot_rdata),
        .rd_data_out   (rd_data_out),
        .rd_data_valid (rd_data_valid),
        .busy          (busy),
        .err_badslot   (err_badslot),
        .err_overrun   (err_overrun),
        .err_timeout   (err_timeout)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        addr_valid = 1'b0;
        data_valid = 1'b0;
        slot_ack   = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cmd_in = 16'h0;
        addr_in = 8'h0;
        data_in = '0;
        idle_inputs();
        slot_rdata = '0;
        slot_rdata[0*DW +: DW] = 40'h00_0000_0A0A;
        slot_rdata[1*DW +: DW] = 40'h01_0203_0405;
        slot_rdata[2*DW +: DW] = 40'h12_3456_789A;
        slot_rdata[3*DW +: DW] = 40'h33_3333_3333;
        slot_rdata[4*DW +: DW] = 40'h44_4444_4444;
        tick(2);
        vectors++;
        if ({slot_req, slot_we, slot_addr, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: req=%b we=%b addr=%h busy=%b want 0",
                     slot_req, slot_we, slot_addr, busy);
        end
        vectors++;
        if ({slot_wdata, rd_data_out, rd_data_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: wdata=%h rd=%h rv=%b want 0",
                     slot_wdata, rd_data_out, rd_data_valid);
        end
        vectors++;
        if ({err_badslot, err_overrun, err_timeout} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_err: got %b want 000",
                     {err_badslot, err_overrun, err_timeout});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_read();
        cmd_in = 16'h0200;
        addr_in = 8'h10;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        vectors++;
        if ({slot_req, slot_we, busy} !== {7'b0000100, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL read_req: req=%b we=%b busy=%b want 0000100 0 1",
                     slot_req, slot_we, busy);
        end
        vectors++;
        if (slot_addr !== 8'h10) begin
            miscompares++;
            $display("FAIL read_addr: got %h want 10", slot_addr);
        end
        tick(2);
        vectors++;
        if ({slot_req, rd_data_valid} !== {7'b0000100, 1'b0}) begin
            miscompares++;
            $display("FAIL read_wait: req=%b rv=%b want 0000100 0",
                     slot_req, rd_data_valid);
        end
        slot_ack = 7'b0000100;
        tick();
        slot_ack = '0;
        vectors++;
        if (rd_data_out !== 40'h12_3456_789A || rd_data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL read_data: rd=%h rv=%b want 123456789a 1",
                     rd_data_out, rd_data_valid);
        end
        vectors++;
        if ({slot_req, busy} !== {7'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL read_resp: req=%b busy=%b want 0 1", slot_req, busy);
        end
        tick();
        vectors++;
        if ({busy, rd_data_valid} !== 2'b00 || rd_data_out !== 40'h12_3456_789A) begin
            miscompares++;
            $display("FAIL read_done: busy=%b rv=%b rd=%h want 0 0 123456789a",
                     busy, rd_data_valid, rd_data_out);
        end
    endtask

    task automatic test_write();
        cmd_in = 16'h8600;
        addr_in = 8'h5C;
        data_in = 40'hAA_BBCC_DDEE;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL write_ignore_av: busy=%b want 0", busy);
        end
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        vectors++;
        if ({slot_req, slot_we} !== {7'b1000000, 1'b1}) begin
            miscompares++;
            $display("FAIL write_req: req=%b we=%b want 1000000 1",
                     slot_req, slot_we);
        end
        vectors++;
        if (slot_wdata !== 40'hAA_BBCC_DDEE || slot_addr !== 8'h5C) begin
            miscompares++;
            $display("FAIL write_data: wdata=%h addr=%h want aabbccddee 5c",
                     slot_wdata, slot_addr);
        end
        slot_ack = 7'b1000000;
        tick();
        slot_ack = '0;
        vectors++;
        if (rd_data_valid !== 1'b0 || rd_data_out !== 40'h12_3456_789A) begin
            miscompares++;
            $display("FAIL write_resp: rv=%b rd=%h want 0 123456789a",
                     rd_data_valid, rd_data_out);
        end
        vectors++;
        if ({slot_req, slot_we, busy} !== {7'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL write_drop: req=%b we=%b busy=%b want 0 0 1",
                     slot_req, slot_we, busy);
        end
        tick();
        data_in = 40'h0;
        cmd_in = 16'h0200;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL read_ignore_dv: busy=%b want 0", busy);
        end
    endtask

    task automatic test_badslot();
        cmd_in = 16'h0700;
        addr_in = 8'h01;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        vectors++;
        if ({err_badslot, slot_req, busy} !== {1'b1, 7'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL bad_pulse: err=%b req=%b busy=%b want 1 0 1",
                     err_badslot, slot_req, busy);
        end
        vectors++;
        if (rd_data_out !== 40'h0 || rd_data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_data: rd=%h rv=%b want 0 1",
                     rd_data_out, rd_data_valid);
        end
        tick();
        vectors++;
        if ({err_badslot, busy, slot_req} !== {1'b0, 1'b0, 7'b0}) begin
            miscompares++;
            $display("FAIL bad_done: err=%b busy=%b req=%b want 0 0 0",
                     err_badslot, busy, slot_req);
        end
    endtask

    task automatic test_overrun();
        cmd_in = 16'h0100;
        addr_in = 8'h22;
        addr_valid = 1'b1;
        tick();
        cmd_in = 16'h0300;
        addr_in = 8'h33;
        tick();
        addr_valid = 1'b0;
        vectors++;
        if (err_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_pulse: got %b want 1", err_overrun);
        end
        vectors++;
        if (slot_req !== 7'b0000010 || slot_addr !== 8'h22) begin
            miscompares++;
            $display("FAIL ovr_keep: req=%b addr=%h want 0000010 22",
                     slot_req, slot_addr);
        end
        slot_ack = 7'b0001000;
        tick();
        slot_ack = '0;
        vectors++;
        if ({slot_req, rd_data_valid, err_overrun} !== {7'b0000010, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL wrong_ack: req=%b rv=%b ovr=%b want 0000010 0 0",
                     slot_req, rd_data_valid, err_overrun);
        end
        slot_ack = 7'b0000010;
        tick();
        slot_ack = '0;
        vectors++;
        if (rd_data_out !== 40'h01_0203_0405 || rd_data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_data: rd=%h rv=%b want 0102030405 1",
                     rd_data_out, rd_data_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        cmd_in = 16'h0000;
        addr_in = 8'h44;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        slot_ack = 7'b0000001;
        tick();
        slot_ack = '0;
        vectors++;
        if (rd_data_out !== 40'h00_0000_0A0A || rd_data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_min_lat: rd=%h rv=%b want a0a 1",
                     rd_data_out, rd_data_valid);
        end
        tick();
        cmd_in = 16'h0300;
        addr_in = 8'h45;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        vectors++;
        if ({slot_req, err_overrun, slot_addr} !== {7'b0001000, 1'b0, 8'h45}) begin
            miscompares++;
            $display("FAIL b2b_accept: req=%b ovr=%b addr=%h want 0001000 0 45",
                     slot_req, err_overrun, slot_addr);
        end
        slot_ack = 7'b0001000;
        tick();
        slot_ack = '0;
        tick();
    endtask

    task automatic test_timeout();
`ifdef SPI_DISPATCH_TIMEOUT_EN
        cmd_in = 16'h0000;
        addr_in = 8'h0F;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        tick(14);
        vectors++;
        if ({slot_req, err_timeout} !== {7'b0000001, 1'b0}) begin
            miscompares++;
            $display("FAIL to_hold: req=%b to=%b want 0000001 0",
                     slot_req, err_timeout);
        end
        tick();
        vectors++;
        if ({err_timeout, rd_data_valid, slot_req} !== {1'b1, 1'b1, 7'b0}) begin
            miscompares++;
            $display("FAIL to_pulse: to=%b rv=%b req=%b want 1 1 0",
                     err_timeout, rd_data_valid, slot_req);
        end
        vectors++;
        if (rd_data_out !== 40'hFF_FFFF_FFFF) begin
            miscompares++;
            $display("FAIL to_fill: rd=%h want ffffffffff", rd_data_out);
        end
        tick();
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        tick(14);
        slot_ack = 7'b0000001;
        tick();
        slot_ack = '0;
        vectors++;
        if ({err_timeout, rd_data_valid} !== 2'b01 ||
            rd_data_out !== 40'h00_0000_0A0A) begin
            miscompares++;
            $display("FAIL to_ack_wins: to=%b rv=%b rd=%h want 0 1 a0a",
                     err_timeout, rd_data_valid, rd_data_out);
        end
        tick();
`else
        cmd_in = 16'h0000;
        addr_in = 8'h0F;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        tick(30);
        vectors++;
        if ({slot_req, err_timeout, busy} !== {7'b0000001, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL no_to_wait: req=%b to=%b busy=%b want 0000001 0 1",
                     slot_req, err_timeout, busy);
        end
        slot_ack = 7'b0000001;
        tick();
        slot_ack = '0;
        vectors++;
        if (rd_data_out !== 40'h00_0000_0A0A || err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL no_to_ack: rd=%h to=%b want a0a 0",
                     rd_data_out, err_timeout);
        end
        tick();
`endif
    endtask

    task automatic test_reset_in_req();
        cmd_in = 16'h8400;
        addr_in = 8'h77;
        data_in = 40'h55_6677_8899;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        vectors++;
        if (slot_req !== 7'b0010000) begin
            miscompares++;
            $display("FAIL rst_pre: req=%b want 0010000", slot_req);
        end
        resetn = 1'b0;
        tick();
        vectors++;
        if ({slot_req, slot_we, busy, slot_addr, slot_wdata, rd_data_out} !== '0) begin
            miscompares++;
            $display("FAIL rst_req: req=%b we=%b busy=%b addr=%h wd=%h rd=%h want 0",
                     slot_req, slot_we, busy, slot_addr, slot_wdata, rd_data_out);
        end
        resetn = 1'b1;
        tick();
        cmd_in = 16'h0100;
        addr_in = 8'h09;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        vectors++;
        if ({slot_req, err_overrun} !== {7'b0000010, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_idle: req=%b ovr=%b want 0000010 0",
                     slot_req, err_overrun);
        end
        slot_ack = 7'b0000010;
        tick();
        slot_ack = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_badslot();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_in_req();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
